// File: rtl/gfx256_write_arbiter_if.sv
// Bundle of requester-side and wishbone-side signals for the pixel-write
// arbiter. The master modport is the arbiter's view: it drives the wbm
// write port and the requester acks. The slave modport is the view of the
// surrounding system (requesters plus the wbm), which drives the rest.
//
// Handshake: a requester raises req_write_i[k] for exactly one cycle and
// holds its addr/sel/dat slices stable until req_ack_o[k] pulses for one
// cycle. On the wbm side, wbm_write_o pulses for one cycle with
// addr/sel/dat valid, and the wbm answers with a one-cycle wbm_ack_i.
// Only one wbm transaction is outstanding at any time.
interface gfx256_write_arbiter_if #(
  parameter int N  = 4,
  parameter int GW = 3
);
  logic [N-1:0]     req_write_i;
  logic [N*27-1:0]  req_addr_i;
  logic [N*32-1:0]  req_sel_i;
  logic [N*256-1:0] req_dat_i;
  logic [N-1:0]     req_ack_o;
  logic             wbm_write_o;
  logic [26:0]      wbm_addr_o;
  logic [31:0]      wbm_sel_o;
  logic [255:0]     wbm_dat_o;
  logic             wbm_ack_i;
  logic [GW-1:0]    grant_o;
  logic             busy_o;
  logic [1:0]       state_o;

  modport master (
    input  req_write_i, req_addr_i, req_sel_i, req_dat_i, wbm_ack_i,
    output req_ack_o, wbm_write_o, wbm_addr_o, wbm_sel_o, wbm_dat_o,
           grant_o, busy_o, state_o
  );

  modport slave (
    output req_write_i, req_addr_i, req_sel_i, req_dat_i, wbm_ack_i,
    input  req_ack_o, wbm_write_o, wbm_addr_o, wbm_sel_o, wbm_dat_o,
           grant_o, busy_o, state_o
  );
endinterface

// File: rtl/gfx256_write_arbiter.sv
// Round-robin arbiter sharing one 256-bit pixel-write wishbone master port
// between N requesters. Write pulses are captured into a pending register,
// a winner is picked from the round-robin pointer upward, and exactly one
// transaction is forwarded to the wbm at a time; its ack is routed back to
// the granted requester as a one-cycle pulse.
module gfx256_write_arbiter #(
  parameter int N  = 4,
  parameter int GW = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  gfx256_write_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  pending;
  logic [N-1:0]  clr_mask;
  logic [N-1:0]  req_ack_q;
  logic [GW-1:0] rr;
  logic [GW-1:0] rr_next;
  logic [GW-1:0] win;
  logic [GW-1:0] grant_q;
  logic          found;
  logic          complete;
  logic          wbm_write_q;
  logic          busy_q;
  logic [26:0]   wbm_addr_q;
  logic [31:0]   wbm_sel_q;
  logic [255:0]  wbm_dat_q;

  // Round-robin search: first pending bit at or above rr, wrapping modulo N.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && pending[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
    rr_next = (int'(win) == N - 1) ? '0 : win + GW'(1);
  end

  // The transaction completes on a wbm ack seen in ISSUE or WAIT; the ack
  // coinciding with the issue cycle counts as well. IDLE ignores stray acks.
  always_comb begin
    complete = bus.wbm_ack_i && ((state == S_ISSUE) || (state == S_WAIT));
    clr_mask = complete ? (N'(1) << grant_q) : '0;
  end

  // Pending requests: a new pulse sets its bit, completion clears the
  // granted bit, and a pulse in the completion cycle keeps it set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_mask) | bus.req_write_i;
    end
  end

  // Grant / issue / wait sequencer with registered wbm and ack outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      rr          <= '0;
      grant_q     <= '0;
      busy_q      <= 1'b0;
      wbm_write_q <= 1'b0;
      wbm_addr_q  <= '0;
      wbm_sel_q   <= '0;
      wbm_dat_q   <= '0;
      req_ack_q   <= '0;
    end else begin
      req_ack_q   <= '0;
      wbm_write_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (found) begin
            wbm_addr_q <= bus.req_addr_i[int'(win)*27 +: 27];
            wbm_sel_q  <= bus.req_sel_i[int'(win)*32 +: 32];
            wbm_dat_q  <= bus.req_dat_i[int'(win)*256 +: 256];
            grant_q    <= win;
            rr         <= rr_next;
            busy_q     <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wbm_write_q <= 1'b1;
          if (complete) begin
            req_ack_q <= clr_mask;
            busy_q    <= 1'b0;
            state     <= S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (complete) begin
            req_ack_q <= clr_mask;
            busy_q    <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ack_o   = req_ack_q;
  assign bus.wbm_write_o = wbm_write_q;
  assign bus.wbm_addr_o  = wbm_addr_q;
  assign bus.wbm_sel_o   = wbm_sel_q;
  assign bus.wbm_dat_o   = wbm_dat_q;
  assign bus.grant_o     = grant_q;
  assign bus.busy_o      = busy_q;
  assign bus.state_o     = state;

endmodule

// File: tb/tb_gfx256_write_arbiter.sv
// Directed bench for gfx256_write_arbiter: exact-latency single request,
// simultaneous requests, fairness, absorbed double pulse, pulse during the
// ack cycle and reset while a wbm ack is outstanding.
module tb_gfx256_write_arbiter;
  localparam int N  = 4;
  localparam int GW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gfx256_write_arbiter_if #(.N(N), .GW(GW)) bus ();

  gfx256_write_arbiter #(.N(N), .GW(GW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- stimulus sources ----------------
  logic [N-1:0]  drv_write = '0;
  logic [N-1:0]  rep_write = '0;
  logic          ack_auto  = 1'b0;
  logic          ack_man   = 1'b0;
  bit            auto_ack  = 1'b1;
  int            ack_dly   = 1;
  bit            rep_en    = 1'b0;
  int            rep_limit [N];
  logic [26:0]   r_addr [N];
  logic [31:0]   r_sel  [N];
  logic [255:0]  r_dat  [N];

  assign bus.req_write_i = drv_write | rep_write;
  assign bus.wbm_ack_i   = ack_auto | ack_man;

  for (genvar k = 0; k < N; k++) begin : g_req
    assign bus.req_addr_i[k*27 +: 27]  = r_addr[k];
    assign bus.req_sel_i[k*32 +: 32]   = r_sel[k];
    assign bus.req_dat_i[k*256 +: 256] = r_dat[k];
  end

  // ---------------- scoreboard state ----------------
  logic [GW-1:0] exp_q[$];
  logic [GW-1:0] last_g = '0;
  logic [GW-1:0] mon_g;
  int            ack_cnt [N];
  int            wr_cnt = 0;
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_acks(input int k, input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (ack_cnt[k] < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 256'(ack_cnt[k]), 256'(target));
  endtask

  // wbm responder: ack ack_dly cycles after each observed write pulse.
  always begin
    @(negedge clk);
    if (bus.wbm_write_o && auto_ack) begin
      repeat (ack_dly) @(posedge clk);
      #1 ack_auto = 1'b1;
      @(posedge clk);
      #1 ack_auto = 1'b0;
    end
  end

  // Monitor: checks each issued write against the expected grant order and
  // the requester data tables, checks ack routing, and re-pulses requesters
  // in the cycle their ack is high when enabled.
  initial begin
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
  end

  always @(negedge clk) begin
    rep_write = '0;
    if (!rst) begin
      if (bus.wbm_write_o) begin
        wr_cnt++;
        check("wr_expected", 256'(exp_q.size() != 0), 256'(1'b1));
        if (exp_q.size() != 0) begin
          mon_g  = exp_q.pop_front();
          last_g = mon_g;
          check("wr_grant", 256'(bus.grant_o), 256'(mon_g));
          check("wr_addr",  256'(bus.wbm_addr_o), 256'(r_addr[mon_g]));
          check("wr_sel",   256'(bus.wbm_sel_o), 256'(r_sel[mon_g]));
          check("wr_dat",   bus.wbm_dat_o, r_dat[mon_g]);
        end
      end
      if (bus.req_ack_o != '0) begin
        check("ack_onehot", 256'($countones(bus.req_ack_o)), 256'(1));
        check("ack_route", 256'(bus.req_ack_o), 256'(N'(1) << last_g));
        for (int k = 0; k < N; k++) begin
          if (bus.req_ack_o[k]) begin
            if (rep_en && ack_cnt[k] < rep_limit[k]) rep_write[k] = 1'b1;
            ack_cnt[k]++;
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int b0, b1, b2, b3, bw;
    r_addr[0] = 27'h0000123; r_sel[0] = 32'h0000000F; r_dat[0] = 256'hAABBCCDD;
    r_addr[1] = 27'h1234567; r_sel[1] = 32'hFFFF0000; r_dat[1] = {8{32'h11112222}};
    r_addr[2] = 27'h2AAAAAA; r_sel[2] = 32'h00FF00FF; r_dat[2] = {4{64'h3333444455556666}};
    r_addr[3] = 27'h7FFFFFF; r_sel[3] = 32'hFFFFFFFF; r_dat[3] = {256{1'b1}};
    for (int k = 0; k < N; k++) rep_limit[k] = 0;

    // Reset state
    tick();
    check("rst_write", 256'(bus.wbm_write_o), 256'(1'b0));
    check("rst_addr",  256'(bus.wbm_addr_o), 256'(27'h0));
    check("rst_sel",   256'(bus.wbm_sel_o), 256'(32'h0));
    check("rst_dat",   bus.wbm_dat_o, 256'h0);
    check("rst_grant", 256'(bus.grant_o), 256'(3'd0));
    check("rst_busy",  256'(bus.busy_o), 256'(1'b0));
    check("rst_ack",   256'(bus.req_ack_o), 256'(4'b0000));
    do_reset();

    // Single request with exact latency, ack two cycles after the write
    ack_dly = 2;
    exp_q.push_back(3'd0);
    drv_write = 4'b0001;                      // cycle T
    tick(); drv_write = '0;                   // T+1
    check("s_busy_t1", 256'(bus.busy_o), 256'(1'b0));
    check("s_wr_t1", 256'(bus.wbm_write_o), 256'(1'b0));
    tick();                                   // T+2
    check("s_busy_t2", 256'(bus.busy_o), 256'(1'b1));
    check("s_grant_t2", 256'(bus.grant_o), 256'(3'd0));
    check("s_wr_t2", 256'(bus.wbm_write_o), 256'(1'b0));
    tick();                                   // T+3
    check("s_wr_t3", 256'(bus.wbm_write_o), 256'(1'b1));
    check("s_addr_t3", 256'(bus.wbm_addr_o), 256'(27'h0000123));
    check("s_sel_t3", 256'(bus.wbm_sel_o), 256'(32'h0000000F));
    check("s_dat_t3", bus.wbm_dat_o, 256'hAABBCCDD);
    tick();                                   // T+4
    check("s_wr_t4", 256'(bus.wbm_write_o), 256'(1'b0));
    tick();                                   // T+5, wbm ack
    check("s_ack_t5", 256'(bus.req_ack_o), 256'(4'b0000));
    tick();                                   // T+6
    check("s_ack_t6", 256'(bus.req_ack_o), 256'(4'b0001));
    check("s_busy_t6", 256'(bus.busy_o), 256'(1'b0));
    tick();                                   // T+7
    check("s_ack_t7", 256'(bus.req_ack_o), 256'(4'b0000));
    check("s_addr_hold", 256'(bus.wbm_addr_o), 256'(27'h0000123));

    // Simultaneous requests from all four, ack one cycle after each issue
    do_reset();
    ack_dly = 1;
    b0 = ack_cnt[0]; b1 = ack_cnt[1]; b2 = ack_cnt[2]; b3 = ack_cnt[3];
    for (int k = 0; k < N; k++) exp_q.push_back(GW'(k));
    drv_write = 4'b1111;
    tick(); drv_write = '0;
    wait_acks(3, b3 + 1, 60, "sim_ack3");
    check("sim_ack0", 256'(ack_cnt[0]), 256'(b0 + 1));
    check("sim_ack1", 256'(ack_cnt[1]), 256'(b1 + 1));
    check("sim_ack2", 256'(ack_cnt[2]), 256'(b2 + 1));
    check("sim_busy", 256'(bus.busy_o), 256'(1'b0));
    check("sim_q_empty", 256'(exp_q.size()), 256'(0));

    // Fairness: requesters 0 and 2 both re-pulse right after their acks
    do_reset();
    b0 = ack_cnt[0]; b2 = ack_cnt[2];
    for (int k = 0; k < N; k++) rep_limit[k] = ack_cnt[k];
    rep_limit[0] = b0 + 2;
    rep_limit[2] = b2 + 2;
    rep_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd2);
    end
    drv_write = 4'b0101;
    tick(); drv_write = '0;
    wait_acks(2, b2 + 3, 120, "fair_ack2");
    check("fair_ack0", 256'(ack_cnt[0]), 256'(b0 + 3));
    check("fair_q_empty", 256'(exp_q.size()), 256'(0));
    rep_en = 1'b0;
    repeat (4) tick();

    // Overlapping pulse: second pulse while the first is pending
    do_reset();
    ack_dly = 2;
    b1 = ack_cnt[1]; bw = wr_cnt;
    exp_q.push_back(3'd1);
    drv_write = 4'b0010;
    tick(); drv_write = '0;
    tick(); drv_write = 4'b0010;
    tick(); drv_write = '0;
    repeat (20) tick();
    check("ovl_writes", 256'(wr_cnt), 256'(bw + 1));
    check("ovl_acks", 256'(ack_cnt[1]), 256'(b1 + 1));
    check("ovl_busy", 256'(bus.busy_o), 256'(1'b0));

    // Pulse in the same cycle the ack is high gives a second write
    do_reset();
    ack_dly = 1;
    b1 = ack_cnt[1]; bw = wr_cnt;
    for (int k = 0; k < N; k++) rep_limit[k] = ack_cnt[k];
    rep_limit[1] = b1 + 1;
    rep_en = 1'b1;
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd1);
    drv_write = 4'b0010;
    tick(); drv_write = '0;
    wait_acks(1, b1 + 2, 60, "sc_acks");
    check("sc_writes", 256'(wr_cnt), 256'(bw + 2));
    rep_en = 1'b0;
    repeat (4) tick();

    // Reset while WAIT is outstanding, then a late wbm ack
    do_reset();
    auto_ack = 1'b0;
    b3 = ack_cnt[3]; bw = wr_cnt;
    exp_q.push_back(3'd3);
    drv_write = 4'b1000;                      // T
    tick(); drv_write = '0;                   // T+1
    tick();                                   // T+2
    tick();                                   // T+3 write
    tick();                                   // T+4 waiting
    check("rw_busy_before", 256'(bus.busy_o), 256'(1'b1));
    rst = 1'b1;
    #1;
    check("rw_write", 256'(bus.wbm_write_o), 256'(1'b0));
    check("rw_addr", 256'(bus.wbm_addr_o), 256'(27'h0));
    check("rw_dat", bus.wbm_dat_o, 256'h0);
    check("rw_grant", 256'(bus.grant_o), 256'(3'd0));
    check("rw_busy", 256'(bus.busy_o), 256'(1'b0));
    tick();
    rst = 1'b0;
    tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    repeat (6) tick();
    check("rw_no_ack", 256'(ack_cnt[3]), 256'(b3));
    check("rw_no_reissue", 256'(wr_cnt), 256'(bw + 1));
    check("rw_state_idle", 256'(bus.state_o), 256'(2'd0));
    check("rw_busy_after", 256'(bus.busy_o), 256'(1'b0));
    auto_ack = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gfx256_write_arbiter.md
Name: gfx256_write_arbiter

Overview:
- Shares the single 256-bit pixel-write wishbone master port between N pixel-write requesters, e.g. the renderer, the blitter/fill engine and the clear engine.
- Each requester uses the renderer's write handshake:
  - a one-cycle write pulse;
  - addr/sel/dat held stable until a one-cycle ack.
- The arbiter grants requesters round-robin, forwards exactly one transaction at a time to the wbm, and routes the ack back to the granted requester.

Parameters:
- N, 4, number of requesters (2..8).
- GW, 3, width of the grant index; must satisfy 2**GW >= N.

Ports:
- clk_i  input  1  system clock; one clock domain; all logic on the rising edge.
- rst_i  input  1  reset; asynchronous, active-high.
- req_write_i  input  N  per-requester write pulse; one cycle long.
- req_addr_i  input  N*27  flattened 256-bit word addresses [31:5]; requester k occupies bits [k*27+26:k*27].
- req_sel_i  input  N*32  flattened byte selects; slice k*32.
- req_dat_i  input  N*256  flattened write data; slice k*256.
- req_ack_o  output  N  per-requester completion pulse.
- wbm_write_o  output  1  write pulse to the wbm.
- wbm_addr_o  output  27  write address [31:5].
- wbm_sel_o  output  32  byte selects.
- wbm_dat_o  output  256  write data.
- wbm_ack_i  input  1  wbm completion pulse.
- grant_o  output  GW  index of the current/last granted requester (debug).
- busy_o  output  1  high while a transaction is outstanding.

Behaviour:
- Reset values (async, on rst_i high):
  - state IDLE; pending = 0; rr pointer = 0.
  - req_ack_o = 0; wbm_write_o = 0; wbm_addr_o/sel/dat = 0.
  - grant_o = 0; busy_o = 0.
- Reset mid-transaction: all pending requests and any outstanding wbm ack are discarded. A wbm_ack_i arriving after reset, while in IDLE, is ignored.
- Pending register:
  - pending[k] is set on the cycle after req_write_i[k].
  - It is cleared on the cycle req_ack_o[k] is driven high.
  - If set and clear coincide, set wins.
  - A second pulse while pending[k] is already 1 is absorbed (no double issue).
- Round-robin selection: search pending from index rr upward, wrapping modulo N. The first set bit is the winner g. After the grant, rr becomes (g+1) mod N.
- FSM states:
  - IDLE: if any pending bit is set, latch the winner's addr/sel/dat into the wbm_* registers, set grant_o = g and busy_o = 1, go to ISSUE. Otherwise stay.
  - ISSUE: wbm_write_o = 1 for exactly this one cycle; go to WAIT.
  - WAIT: wbm_write_o = 0.
    - On wbm_ack_i: pulse req_ack_o[g] high for one cycle (registered, next cycle), clear pending[g], set busy_o = 0, go to IDLE.
    - A wbm_ack_i already asserted during ISSUE is also honoured as completion.
- Latency:
  - req_write_i at cycle T with the arbiter idle gives wbm_write_o high at T+3 (pending at T+1, grant at T+2, issue at T+3).
  - wbm_ack_i at cycle A gives req_ack_o at A+1.
  - The earliest next wbm_write_o is at A+3.
- Output stability: wbm_addr_o/sel/dat are held from grant until the next grant. Requester inputs are sampled only at grant.
- req_ack_o is one-hot or zero, never more than one bit.
- Stray wbm_ack_i in IDLE is ignored.

Test Plan:
- Single request: requester 0 pulses with addr=27'h0000123, sel=32'h0000000F, dat=0xAABBCCDD in the low word. Required: wbm_write_o for 1 cycle at T+3 with identical addr/sel/dat. Ack returned 2 cycles later gives req_ack_o=4'b0001 for 1 cycle.
- Simultaneous requests: all four pulse in the same cycle, rr=0, wbm acks 1 cycle after each issue. Required: grant order 0,1,2,3; each req_ack_o bit pulses exactly once; busy_o drops after the fourth ack.
- Fairness: requester 0 re-pulses immediately after each of its acks while requester 2 has a pulse pending. Required: grants alternate 0,2,0,... and requester 2 is never starved.
- Overlapping pulse: requester 1 pulses again while its first request is pending and not yet acked. Required: only one wbm write is issued for it.
- Set/clear coincidence: requester 1 pulses in the same cycle its req_ack_o is high. Required: pending stays set and a second write is issued.
- Reset mid-WAIT: assert rst_i while WAIT is outstanding, then deliver wbm_ack_i after reset. Required: all outputs return to 0; no req_ack_o is produced; pending is empty.
